uart_tx_core: RTL

Serial transmitter for the Basys3 UART link. It accepts one byte per valid/ready handshake and drives it on `tx` as an 8N1 frame: start bit, eight data bits LSB first, stop bit(s). The bit period is derived from the 100 MHz system clock. It pairs with the on-board UART receiver, which decodes the frames this block produces.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_core.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter and receiver state encodings, frame width
// and the default baud divider for the 100 MHz Basys3 clock.
package uart_pkg;

  localparam int UART_DATA_BITS          = 8;
  localparam int UART_BAUD_SCALE_DEFAULT = 10416;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    TX_IDLE   = ST_IDLE,
    TX_START  = ST_START,
    TX_DATA   = ST_DATA,
    TX_PARITY = ST_PARITY,
    TX_STOP   = ST_STOP
  } tx_state_e;

  // Receiver state encodings, kept here so both directions share one package.
  localparam logic [2:0] RX_IDLE    = 3'd0;
  localparam logic [2:0] RX_START   = 3'd1;
  localparam logic [2:0] RX_DATA    = 3'd2;
  localparam logic [2:0] RX_STOP    = 3'd3;
  localparam logic [2:0] RX_CLEANUP = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_SCALE-1 and flags the terminal count.
// clr holds/restarts the count at 0.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_SCALE = UART_BAUD_SCALE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = $clog2(BAUD_SCALE);
  localparam logic [CW-1:0]   TERM = CW'(BAUD_SCALE - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            count <= '0;
    else if (clr || tick) count <= '0;
    else                  count <= count + CW'(1);
  end

  assign tick = (count == TERM);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: 8N1/8N2 frames, one byte per valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1/8E2).
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int BAUD_SCALE = UART_BAUD_SCALE_DEFAULT,
  parameter int STOP_BITS  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      ready,
  output logic                      tx,
  output logic                      done
);

  tx_state_e                 state, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx, bit_idx_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic                      tick;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  // Counter is held at zero while idle, so the accept edge starts START at count 0.
  uart_baud_tick #(.BAUD_SCALE(BAUD_SCALE)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (state == TX_IDLE),
    .tick  (tick)
  );

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    state_d   = state;
    shift_d   = shift_q;
    bit_idx_d = bit_idx;
    tx_d      = tx_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          shift_d   = data;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
          state_d   = TX_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^data;
`endif
        end
      end
      TX_START: if (tick) begin
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
        state_d = TX_DATA;
      end
      TX_DATA: if (tick) begin
        if (bit_idx == 3'd7) begin
          bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          tx_d      = parity_q;
          state_d   = TX_PARITY;
`else
          tx_d      = 1'b1;
          state_d   = TX_STOP;
`endif
        end else begin
          bit_idx_d = bit_idx + 3'd1;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: if (tick) begin
        tx_d    = 1'b1;
        state_d = TX_STOP;
      end
`endif
      // bit_idx doubles as the stop-bit counter.
      TX_STOP: if (tick) begin
        if (bit_idx == 3'(STOP_BITS - 1)) begin
          bit_idx_d = 3'd0;
          done_d    = 1'b1;
          state_d   = TX_IDLE;
        end else begin
          bit_idx_d = bit_idx + 3'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  // NOTE: the shift register is reset too, so an aborted frame leaves no stale byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= TX_IDLE;
      shift_q  <= '0;
      bit_idx  <= 3'd0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      shift_q  <= shift_d;
      bit_idx  <= bit_idx_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ready = (state == TX_IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

endmodule
